// File: rtl/uart_retrans_pkg.sv
// Shared types and defaults for the UART retransmission path (rx controller and tx-side logic).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_retrans_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RESEND = 2'd1,
    HOLD        = 2'd2,
    FAIL        = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_MAX_RETRIES    = 2;

  // Width of a counter holding 0..max_retries, never narrower than one bit.
  function automatic int retry_w(input int max_retries);
    return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Resend timeout timer: counts cycles while run=1, expire decodes the last count of the window.
// Latency: expire is high in the cycle the count reaches TIMEOUT_CYCLES-1 (decoded from a flop).
// Backpressure: none; clear restarts the window and has priority over run.
module uart_timeout_timer
  import uart_retrans_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: the owner clears on every resend, so the count never passes LAST while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_retrans_ctrl.sv
// Receive-side retransmission controller: parity-checks frames, requests bounded resends, holds bytes.
// Latency: one cycle from rx_done/ack sample to registered valid/error/resend_req/overrun.
// Backpressure: a held byte or error blocks new frames until ack; frames arriving meanwhile are dropped with overrun.
module uart_retrans_ctrl
  import uart_retrans_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int DATA_W         = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_done,
  input  logic [DATA_W-1:0]               rx_data,
  input  logic                            rx_parity_ok,
  input  logic                            ack,
  output logic                            resend_req,
  output logic [DATA_W-1:0]               data_out,
  output logic                            valid,
  output logic                            error,
  output logic [retry_w(MAX_RETRIES)-1:0] retries_used,
  output logic                            overrun
);

  localparam int RW = retry_w(MAX_RETRIES);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0]     retries_q, retries_d;
  logic              resend_req_q, resend_req_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              overrun_q, overrun_d;
  logic              tmr_run;
  logic              tmr_expire;

  assign tmr_run = (state_q == WAIT_RESEND);

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (resend_req_d),
    .run    (tmr_run),
    .expire (tmr_expire)
  );

  // Next-state and next-output computation; a good frame beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    retries_d    = retries_q;
    resend_req_d = 1'b0;
    overrun_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          if (rx_parity_ok) begin
            data_d  = rx_data;
            state_d = HOLD;
          end else if (MAX_RETRIES > 0) begin
            resend_req_d = 1'b1;
            retries_d    = RW'(1);
            state_d      = WAIT_RESEND;
          end else begin
            state_d = FAIL;
          end
        end
      end
      WAIT_RESEND: begin
        if (rx_done && rx_parity_ok) begin
          data_d  = rx_data;
          state_d = HOLD;
        end else if (rx_done || tmr_expire) begin
          if (retries_q < MAX_R) begin
            resend_req_d = 1'b1;
            retries_d    = retries_q + RW'(1);
          end else begin
            state_d = FAIL;
          end
        end
      end
      HOLD, FAIL: begin
        // Frames arriving here are never queued, even when ack lands in the same cycle.
        overrun_d = rx_done;
        if (ack) begin
          retries_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HOLD);
    error_d = (state_d == FAIL);
  end

  // State, hold register, retry counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      retries_q    <= '0;
      resend_req_q <= 1'b0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      retries_q    <= retries_d;
      resend_req_q <= resend_req_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      overrun_q    <= overrun_d;
    end
  end

  assign resend_req   = resend_req_q;
  assign data_out     = data_q;
  assign valid        = valid_q;
  assign error        = error_q;
  assign retries_used = retries_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/uart_retrans_ctrl.md
# uart_retrans_ctrl

Receive-side retransmission controller for the UART link. It sits between the UART frame receiver and the byte consumer. Each received frame is parity-checked. On a parity failure or a missing frame, the block requests resends up to a bounded retry count, using its own timeout timer. Each accepted byte is held for the consumer under a valid/ack handshake; an unrecoverable frame is reported as an error.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for a resent frame before the attempt counts as lost; ≥2.
- MAX_RETRIES, 2: maximum resend requests per frame; ≥0.
- DATA_W, 8: frame payload width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- rx_done  in  1  one-cycle pulse: a frame has arrived.
- rx_data  in  DATA_W  frame payload, valid with rx_done.
- rx_parity_ok  in  1  parity check result, valid with rx_done.
- ack  in  1  consumer accepts the held byte or acknowledges the error.
- resend_req  out  1  one-cycle pulse asking the transmitter to resend.
- data_out  out  DATA_W  held payload, stable while valid=1.
- valid  out  1  data_out holds an accepted byte.
- error  out  1  frame lost after MAX_RETRIES resends.
- retries_used  out  RW  resends issued for the current frame; RW = $clog2(MAX_RETRIES+1), minimum 1.
- overrun  out  1  one-cycle pulse: a frame arrived while the block was in HOLD or FAIL and was dropped.

## Operation
- Reset values: state IDLE; resend_req, valid, error, overrun = 0; data_out = 0; retries_used = 0; timer = 0.
- IDLE, on rx_done:
  - parity ok: latch rx_data, go to HOLD.
  - parity bad, MAX_RETRIES>0: pulse resend_req, retries_used=1, timer=0, go to WAIT_RESEND.
  - parity bad, MAX_RETRIES=0: go to FAIL.
- IDLE, no rx_done: stay; ack is ignored.
- WAIT_RESEND: timer increments each cycle. The attempt fails on rx_done with bad parity, or when timer reaches TIMEOUT_CYCLES-1 with no rx_done.
  - rx_done with good parity: latch data, go to HOLD.
  - Attempt fails, retries_used<MAX_RETRIES: pulse resend_req, retries_used+1, timer=0, stay.
  - Attempt fails, retries_used=MAX_RETRIES: go to FAIL.
- Good rx_done in the same cycle as timer expiry: the good frame wins, go to HOLD.
- HOLD: valid=1, data_out frozen.
  - ack: go to IDLE, clear retries_used.
  - rx_done: frame dropped, overrun pulse.
- FAIL: error=1.
  - ack: go to IDLE, clear retries_used.
  - rx_done: frame dropped, overrun pulse.
- Simultaneous ack and rx_done in HOLD/FAIL: ack is taken, the frame is dropped with overrun; it is not re-processed in IDLE.
- retries_used stays visible through HOLD/FAIL until ack.
- Reset mid-operation: returns to IDLE next edge with all outputs at reset values; any pending resend is abandoned.

## Timing
- All outputs are registered.
- rx_done at edge N → valid, resend_req, or error asserted after edge N, i.e. visible in cycle N+1.
- ack sampled at edge M while valid/error=1 → valid/error low in cycle M+1. The earliest next acceptance is an rx_done sampled at edge M+1.
- Timeout window: resend_req pulse in cycle K; an absent frame causes the next resend_req or error in cycle K+TIMEOUT_CYCLES.
- resend_req is never high two consecutive cycles, except when back-to-back bad frames arrive in WAIT_RESEND.
- Timer width is $clog2(TIMEOUT_CYCLES); the timer saturates logic-free because it is cleared on every resend.

## Structure
- Shared package uart_retrans_pkg:
  - state enum IDLE/WAIT_RESEND/HOLD/FAIL (2-bit);
  - default TIMEOUT_CYCLES and MAX_RETRIES constants, shared with the transmitter-side logic.
- Sub-module uart_timeout_timer (parameter TIMEOUT_CYCLES; inputs clk, reset, clear, run; output expire pulse).
- FSM, data hold register and retry counter live in the top.

## Test plan
TIMEOUT_CYCLES=16, MAX_RETRIES=2 unless stated.
- Clean frame: rx_done, 0xA5, parity ok → valid=1, data_out=0xA5 next cycle, retries_used=0; ack → valid=0 next cycle.
- One bad frame, then good resend 5 cycles later with 0x3C → one resend_req pulse, then valid=1, data_out=0x3C, retries_used=1.
- Bad frame, then no response → resend_req at cycles 1 and 17, error=1 at cycle 33, retries_used=2; ack clears error.
- Good rx_done (0x11) exactly at the timer-expiry cycle → valid=1 with 0x11, no extra resend_req.
- rx_done 0x77 during HOLD holding 0x55 → overrun pulse, data_out stays 0x55. Also MAX_RETRIES=0 with a bad frame → error next cycle, no resend_req.
- reset asserted in WAIT_RESEND → all outputs 0 next cycle. A subsequent good frame 0x0F → valid with retries_used=0.
